// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings, constants and operand-match helper for the
// pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_MD_WAIT  = 2'd2
  } hz_state_e;

  localparam logic        ZERO      = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'd0;

  // True when an ID source operand is actually read and names the given rd.
  function automatic logic reg_match(input logic used, input logic [4:0] id_rs,
                                     input logic [4:0] rd);
    return used & (id_rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
// x0 is hardwired to zero and never creates a dependency.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       hazard_o
);

  assign hazard_o = ex_mem_read_i & (ex_rd_i != 5'd0) &
                    (reg_match(id_rs1_used_i, id_rs1_i, ex_rd_i) |
                     reg_match(id_rs2_used_i, id_rs2_i, ex_rd_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory and mul/div waits,
// EX-resolved control transfers, load-use bubbles, watchdog and stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             jump_taken_ex_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             md_start_i,
  input  logic             md_done_i,
  output logic             pc_stall_o,
  output logic             PL_stall_ex,
  output logic             PL_flush,
  output logic             id_ex_bubble_o,
  output logic             ex_hold_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  hz_state_e        state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hazard_s;
  logic mem_miss_s, md_busy_s, wait_stall_s, release_s;
  logic pc_stall_s, if_stall_s, flush_s, bubble_s;

  load_use_detect u_load_use_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .hazard_o      (lu_hazard_s)
  );

  // The access aborted by the watchdog is ignored during the timeout pulse cycle.
  assign mem_miss_s = dmem_req_i & ~dmem_ready_i & ~mem_timeout_q;
  assign md_busy_s  = md_start_i & ~md_done_i;

  // Next-state, wait counter and stall/flush decode in priority order.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = ZERO;
    wait_stall_s  = ZERO;
    release_s     = ZERO;
    case (state_q)
      HZ_RUN: begin
        if (mem_miss_s) begin
          wait_stall_s = 1'b1;
          wait_cnt_d   = 8'd1;
          if (wait_cnt_d == TIMEOUT_C) begin
            mem_timeout_d = 1'b1;
          end else begin
            state_d = HZ_MEM_WAIT;
          end
        end else if (md_busy_s) begin
          wait_stall_s = 1'b1;
          state_d      = HZ_MD_WAIT;
        end else begin
          release_s = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        if (dmem_ready_i) begin
          release_s = 1'b1;
          state_d   = HZ_RUN;
        end else begin
          wait_stall_s = 1'b1;
          wait_cnt_d   = wait_cnt_q + 8'd1;
          if (wait_cnt_d == TIMEOUT_C) begin
            mem_timeout_d = 1'b1;
            state_d       = HZ_RUN;
          end else begin
            state_d = HZ_MEM_WAIT;
          end
        end
      end
      HZ_MD_WAIT: begin
        if (md_done_i) begin
          release_s = 1'b1;
          state_d   = HZ_RUN;
        end else begin
          wait_stall_s = 1'b1;
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    // Deferred jumps flush in the release cycle; flush outranks load-use.
    pc_stall_s = wait_stall_s;
    if_stall_s = wait_stall_s;
    flush_s    = ZERO;
    bubble_s   = ZERO;
    if (release_s && jump_taken_ex_i) begin
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (release_s && lu_hazard_s) begin
      pc_stall_s = 1'b1;
      if_stall_s = 1'b1;
      bubble_s   = 1'b1;
    end else begin
      flush_s = ZERO;
    end

    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, if_stall_s};
  end

  assign pc_stall_o     = pc_stall_s & rst_n;
  assign PL_stall_ex    = if_stall_s & rst_n;
  assign PL_flush       = flush_s & rst_n;
  assign id_ex_bubble_o = bubble_s & rst_n;
  assign ex_hold_o      = wait_stall_s & rst_n;
  assign mem_timeout_o  = mem_timeout_q;
  assign stall_cnt_o    = stall_cnt_q;

  // State, watchdog, timeout pulse and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HZ_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's hand-derived
// expectation is queued at drive time and popped when outputs settle.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        rs1_used, rs2_used, ex_mem_read, jump, dreq, drdy, md_start, md_done;
  logic        pc_stall, stall_ex, flush, bubble, hold, mem_to;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  flags;
    logic        to;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  // flags = {pc_stall, PL_stall_ex, PL_flush, id_ex_bubble, ex_hold}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_LU   = 5'b11010;
  localparam logic [4:0] F_FL   = 5'b00110;
  localparam logic [4:0] F_WT   = 5'b11001;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_rs1_used_i   (rs1_used),
    .id_rs2_used_i   (rs2_used),
    .ex_rd_i         (ex_rd),
    .ex_mem_read_i   (ex_mem_read),
    .jump_taken_ex_i (jump),
    .dmem_req_i      (dreq),
    .dmem_ready_i    (drdy),
    .md_start_i      (md_start),
    .md_done_i       (md_done),
    .pc_stall_o      (pc_stall),
    .PL_stall_ex     (stall_ex),
    .PL_flush        (flush),
    .id_ex_bubble_o  (bubble),
    .ex_hold_o       (hold),
    .mem_timeout_o   (mem_to),
    .stall_cnt_o     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check settled outputs.
  task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                     input logic jmp, input logic req, input logic rdy, input logic mst,
                     input logic mdn, input logic [4:0] ef, input logic eto, input int ecnt);
    exp_t e;
    @(negedge clk);
    rst_n = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; rs1_used = u1; rs2_used = u2;
    ex_mem_read = mr; jump = jmp; dreq = req; drdy = rdy; md_start = mst; md_done = mdn;
    e.flags = ef; e.to = eto; e.cnt = ecnt;
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("flags", {27'd0, pc_stall, stall_ex, flush, bubble, hold}, {27'd0, e.flags});
      check_val("mem_timeout", {31'd0, mem_to}, {31'd0, e.to});
      check_val("stall_cnt", stall_cnt, e.cnt);
      if (stall_ex && flush) check_val("flush_and_stall", 32'd1, 32'd0);
      if (hold && flush) check_val("hold_and_flush", 32'd1, 32'd0);
    end
  endtask

  initial begin
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    ex_mem_read = 1'b0; jump = 1'b0; dreq = 1'b0; drdy = 1'b0; md_start = 1'b0; md_done = 1'b0;
    //  rst rs1   rs2   rd    u1 u2 mr jmp req rdy mst mdn flags  to cnt
    cyc(0, 5'd5, 5'd0, 5'd5, 1, 0, 1, 1,  1,  0,  1,  0,  F_NONE, 0, 0);  // in reset
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 0);
    cyc(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0,  0,  0,  0,  0,  F_LU,   0, 0);  // load-use rs1
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 1);
    cyc(1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0,  0,  0,  0,  0,  F_NONE, 0, 1);  // x0 never hazards
    cyc(1, 5'd3, 5'd7, 5'd7, 1, 1, 1, 0,  0,  0,  0,  0,  F_LU,   0, 1);  // load-use rs2
    cyc(1, 5'd3, 5'd7, 5'd7, 1, 0, 1, 0,  0,  0,  0,  0,  F_NONE, 0, 2);  // rs2 not read
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,  0,  0,  0,  0,  F_FL,   0, 2);  // jump
    for (int i = 0; i < 3; i++)                                          // mem wait + jump
      cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0, F_WT, 0, 2 + i);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,  1,  1,  0,  0,  F_FL,   0, 5);  // release + flush
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 5);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1,  1,  0,  0,  F_NONE, 0, 5);  // ready at once
    for (int i = 0; i < 4; i++)                                          // watchdog
      cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, F_WT, 0, 5 + i);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1,  0,  0,  0,  F_NONE, 1, 9);  // timeout pulse
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 9);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  1,  0,  F_WT,   0, 9);  // mul/div start
    for (int i = 0; i < 4; i++)                                          // md wait, load-use masked
      cyc(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 1, 0, F_WT, 0, 10 + i);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  1,  1,  F_NONE, 0, 14); // md done
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  1,  1,  F_NONE, 0, 14); // start+done
    cyc(1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 1,  0,  0,  0,  0,  F_FL,   0, 14); // flush beats load-use
    for (int i = 0; i < 3; i++)
      cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, F_WT, 0, 14 + i);
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  1,  0,  0,  0,  F_NONE, 0, 0);  // reset mid-wait
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 0);  // no pulse after
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0,  0,  0,  0,  F_NONE, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
